// File: rtl/alu_arbiter_if.sv
// Handshake and ALU bus between two requesters, the arbiter and the shared ALU.
// The arbiter connects through the slave modport; the requesters and the ALU connect through master.
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req1_valid;
  logic              req0_ready;
  logic              req1_ready;
  logic [3:0]        req0_op;
  logic [3:0]        req1_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic              rsp0_ready;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic              busy;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b,
           rsp0_ready, rsp1_ready, alu_res,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_data, alu_op, alu_a, alu_b, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b,
           rsp0_ready, rsp1_ready, alu_res,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_data, alu_op, alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); otherwise round-robin.
//
// state | meaning
// IDLE  | waiting for a request; ready goes to the granted requester
// EXEC  | latched operands drive the ALU; result registered at end of cycle
// RESP  | rsp_valid to the latched grant id until its rsp_ready
module alu_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_gnt_id;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_rsp_data;
  logic              w_gnt_id;
  logic              w_hs;
  logic              w_consume;
  logic              w_op_legal;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic              r_prio;
`endif

  // Grant: a lone valid requester always wins; only a tie consults the policy.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    w_gnt_id = ~bus.req0_valid;
`else
    if (bus.req0_valid && bus.req1_valid) w_gnt_id = r_prio;
    else                                  w_gnt_id = ~bus.req0_valid;
`endif
  end

  always_comb begin
    case (r_op)
      4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b0101, 4'b1101, 4'b0110, 4'b0111: w_op_legal = 1'b1;
      default:                                     w_op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_hs           = 1'b0;
    w_consume      = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req0_ready = bus.req0_valid & ~w_gnt_id;
        bus.req1_ready = bus.req1_valid &  w_gnt_id;
        w_hs           = bus.req0_valid | bus.req1_valid;
        if (w_hs) w_next = S_EXEC;
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        bus.rsp0_valid = ~r_gnt_id;
        bus.rsp1_valid =  r_gnt_id;
        w_consume      = r_gnt_id ? bus.rsp1_ready : bus.rsp0_ready;
        if (w_consume) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt_id   <= 1'b0;
      r_op       <= 4'b0000;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_data <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_prio     <= 1'b0;
`endif
    end else begin
      if (w_hs) begin
        r_gnt_id <= w_gnt_id;
        r_op     <= w_gnt_id ? bus.req1_op : bus.req0_op;
        r_a      <= w_gnt_id ? bus.req1_a  : bus.req0_a;
        r_b      <= w_gnt_id ? bus.req1_b  : bus.req0_b;
      end
      // Undefined op codes never expose whatever the ALU happens to produce.
      if (r_state == S_EXEC) r_rsp_data <= w_op_legal ? bus.alu_res : '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      if (w_consume) r_prio <= ~r_gnt_id;
`endif
    end
  end

  assign bus.alu_op   = r_op;
  assign bus.alu_a    = r_a;
  assign bus.alu_b    = r_b;
  assign bus.rsp_data = r_rsp_data;
  assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a small ALU model drives alu_res, and the arbitration and result expectations come from a behavioural model.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if bus ();

  alu_arbiter u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  int m_prio = 0;

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b0000: return a + b;
      4'b1000: return a - b;
      4'b0001: return a << b[4:0];
      4'b0010: return {31'd0, ($signed(a) < $signed(b))};
      4'b0011: return {31'd0, (a < b)};
      4'b0100: return a ^ b;
      4'b0101: return a >> b[4:0];
      4'b1101: return $signed(a) >>> b[4:0];
      4'b0110: return a & b;
      4'b0111: return a | b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    case (op)
      4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd13, 4'd6, 4'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] expect_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    return is_legal(op) ? alu_fn(op, a, b) : 32'd0;
  endfunction

  assign bus.alu_res = alu_fn(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_op = 4'd0; bus.req1_op = 4'd0;
    bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  // Presents the requests and returns which requester handshook (-1 on timeout, 2 if both saw ready).
  task automatic issue(input bit v0, input bit v1, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       output int gnt, output int waits);
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    gnt = -1;
    waits = 0;
    while (gnt < 0 && waits < 20) begin
      #1;
      if (bus.req0_ready && bus.req1_ready) gnt = 2;
      else if (bus.req0_ready)              gnt = 0;
      else if (bus.req1_ready)              gnt = 1;
      if (gnt < 0) waits++;
      step();
    end
    if (gnt == 0 || gnt == 2) bus.req0_valid = 1'b0;
    if (gnt == 1 || gnt == 2) bus.req1_valid = 1'b0;
  endtask

  // Waits for the response of requester id, holds off the consume for `hold` cycles, then consumes.
  task automatic wait_rsp(input int id, input int hold, input bit spurious,
                          output int lat, output logic [31:0] data, output bit stable, output bit quiet, output bit timeout);
    bit own;
    lat = 1; stable = 1'b1; quiet = 1'b1; timeout = 1'b0; data = 32'd0;
    #1;
    own = (id == 1) ? bus.rsp1_valid : bus.rsp0_valid;
    while (!own && lat < 20) begin
      if (bus.req0_ready || bus.req1_ready || bus.rsp0_valid || bus.rsp1_valid || !bus.busy) quiet = 1'b0;
      step(); #1;
      lat++;
      own = (id == 1) ? bus.rsp1_valid : bus.rsp0_valid;
    end
    if (!own) begin
      timeout = 1'b1;
      return;
    end
    data = bus.rsp_data;
    for (int h = 0; h < hold; h++) begin
      if (spurious) begin
        if (id == 1) bus.rsp0_ready = 1'b1;
        else         bus.rsp1_ready = 1'b1;
      end
      if (bus.rsp_data !== data) stable = 1'b0;
      own = (id == 1) ? bus.rsp1_valid : bus.rsp0_valid;
      if (bus.req0_ready || bus.req1_ready || !own || !bus.busy ||
          ((id == 1) ? bus.rsp0_valid : bus.rsp1_valid)) quiet = 1'b0;
      step(); #1;
    end
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    if (bus.rsp_data !== data) stable = 1'b0;
    own = (id == 1) ? bus.rsp1_valid : bus.rsp0_valid;
    if (!own) quiet = 1'b0;
    if (id == 1) bus.rsp1_ready = 1'b1;
    else         bus.rsp0_ready = 1'b1;
    step();
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", bus.busy); end
    total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_req0_ready got=%0b want=0", bus.req0_ready); end
    total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_req1_ready got=%0b want=0", bus.req1_ready); end
    total++; if (bus.rsp0_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp0_valid got=%0b want=0", bus.rsp0_valid); end
    total++; if (bus.rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp1_valid got=%0b want=0", bus.rsp1_valid); end
    total++; if (bus.rsp_data !== 32'd0) begin bad++; $display("FAIL reset_rsp_data got=%h want=0", bus.rsp_data); end
    total++; if (bus.alu_op !== 4'd0) begin bad++; $display("FAIL reset_alu_op got=%h want=0", bus.alu_op); end
    total++; if (bus.alu_a !== 32'd0) begin bad++; $display("FAIL reset_alu_a got=%h want=0", bus.alu_a); end
    total++; if (bus.alu_b !== 32'd0) begin bad++; $display("FAIL reset_alu_b got=%h want=0", bus.alu_b); end
    m_prio = 0;
  endtask

  task automatic test_single();
    int gnt, waits, lat;
    logic [31:0] data;
    bit stable, quiet, tmo;
    issue(1'b1, 1'b0, 4'b0000, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, gnt, waits);
    total++; if (gnt !== 0) begin bad++; $display("FAIL single_gnt got=%0d want=0", gnt); end
    total++; if (waits !== 0) begin bad++; $display("FAIL single_accept_wait got=%0d want=0", waits); end
    wait_rsp(0, 0, 1'b0, lat, data, stable, quiet, tmo);
    total++; if (tmo !== 1'b0) begin bad++; $display("FAIL single_timeout got=%0b want=0", tmo); end
    total++; if (lat !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", lat); end
    total++; if (data !== 32'd12) begin bad++; $display("FAIL single_data got=%h want=%h", data, 32'd12); end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL single_busy_window got=%0b want=1", quiet); end
    #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%0b want=0", bus.busy); end
    total++; if ({bus.alu_a, bus.alu_b} !== {32'd5, 32'd7}) begin bad++; $display("FAIL single_alu_hold got=%h want=%h", {bus.alu_a, bus.alu_b}, {32'd5, 32'd7}); end
    m_prio = 1;
  endtask

  task automatic test_round_robin();
    int gnt, waits, lat, exp_gnt;
    logic [31:0] data;
    bit stable, quiet, tmo;
    rst = 1'b1; step(); rst = 1'b0;
    m_prio = 0;
    for (int r = 0; r < 3; r++) begin
      exp_gnt = FIXED ? 0 : m_prio;
      issue(1'b1, 1'b1, 4'b1000, 32'd10, 32'd3, 4'b1000, 32'd10, 32'd3, gnt, waits);
      total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt round=%0d got=%0d want=%0d", r, gnt, exp_gnt); end
      total++; if (waits !== 0) begin bad++; $display("FAIL rr_throughput round=%0d got=%0d want=0", r, waits); end
      wait_rsp(exp_gnt, 0, 1'b0, lat, data, stable, quiet, tmo);
      total++; if (data !== 32'd7 || lat !== 2 || tmo) begin bad++; $display("FAIL rr_rsp round=%0d got=%h/%0d want=%h/2", r, data, lat, 32'd7); end
      m_prio = 1 - exp_gnt;
    end
  endtask

  task automatic test_backpressure();
    int gnt, waits, lat;
    logic [31:0] data;
    bit stable, quiet, tmo;
    issue(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'b0110, 32'h0000_F0F0, 32'h0000_FF00, gnt, waits);
    total++; if (gnt !== 1) begin bad++; $display("FAIL bp_gnt got=%0d want=1", gnt); end
    bus.req0_valid = 1'b1;
    wait_rsp(1, 5, 1'b0, lat, data, stable, quiet, tmo);
    bus.req0_valid = 1'b0;
    total++; if (data !== 32'h0000_F000 || tmo) begin bad++; $display("FAIL bp_data got=%h want=%h", data, 32'h0000_F000); end
    total++; if (stable !== 1'b1) begin bad++; $display("FAIL bp_stable got=%0b want=1", stable); end
    total++; if (quiet !== 1'b1) begin bad++; $display("FAIL bp_ready_low got=%0b want=1", quiet); end
    m_prio = 0;
  endtask

  task automatic test_illegal();
    int gnt, waits, lat;
    logic [31:0] data;
    bit stable, quiet, tmo;
    issue(1'b1, 1'b0, 4'b1111, 32'd1, 32'd1, 4'd0, 32'd0, 32'd0, gnt, waits);
    total++; if (gnt !== 0) begin bad++; $display("FAIL illegal_gnt got=%0d want=0", gnt); end
    wait_rsp(0, 1, 1'b0, lat, data, stable, quiet, tmo);
    total++; if (data !== 32'd0 || lat !== 2 || tmo) begin bad++; $display("FAIL illegal_data got=%h/%0d want=0/2", data, lat); end
    m_prio = 1;
  endtask

  task automatic test_reset_mid();
    int gnt, waits, lat;
    logic [31:0] data;
    bit stable, quiet, tmo, leak;
    issue(1'b1, 1'b0, 4'b0000, 32'd9, 32'd9, 4'd0, 32'd0, 32'd0, gnt, waits);
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rstmid_exec_busy got=%0b want=1", bus.busy); end
    rst = 1'b1; step(); rst = 1'b0; #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%0b want=0", bus.busy); end
    total++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin bad++; $display("FAIL rstmid_rsp_valid got=%b want=00", {bus.rsp0_valid, bus.rsp1_valid}); end
    total++; if (bus.alu_a !== 32'd0) begin bad++; $display("FAIL rstmid_alu_a got=%h want=0", bus.alu_a); end
    total++; if (bus.rsp_data !== 32'd0) begin bad++; $display("FAIL rstmid_rsp_data got=%h want=0", bus.rsp_data); end
    leak = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      if (bus.rsp0_valid || bus.rsp1_valid || bus.busy) leak = 1'b1;
    end
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp got=%0b want=0", leak); end
    m_prio = 0;
    issue(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'b0111, 32'd1, 32'd2, gnt, waits);
    total++; if (gnt !== 1) begin bad++; $display("FAIL rstmid_new_gnt got=%0d want=1", gnt); end
    wait_rsp(1, 0, 1'b0, lat, data, stable, quiet, tmo);
    total++; if (data !== 32'd3 || lat !== 2 || tmo) begin bad++; $display("FAIL rstmid_new_data got=%h/%0d want=3/2", data, lat); end
    m_prio = 0;
  endtask

  task automatic test_spurious();
    int gnt, waits, lat;
    logic [31:0] data;
    bit stable, quiet, tmo;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    step();
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    #1;
    total++; if ({bus.busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin bad++; $display("FAIL spur_idle got=%b want=000", {bus.busy, bus.rsp0_valid, bus.rsp1_valid}); end
    issue(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 4'b0100, 32'h1234_5678, 32'h0F0F_0F0F, gnt, waits);
    total++; if (gnt !== 1) begin bad++; $display("FAIL spur_gnt got=%0d want=1", gnt); end
    wait_rsp(1, 3, 1'b1, lat, data, stable, quiet, tmo);
    total++; if (data !== (32'h1234_5678 ^ 32'h0F0F_0F0F) || tmo) begin bad++; $display("FAIL spur_data got=%h want=%h", data, 32'h1234_5678 ^ 32'h0F0F_0F0F); end
    total++; if (quiet !== 1'b1 || stable !== 1'b1) begin bad++; $display("FAIL spur_pending got=%0b%0b want=11", quiet, stable); end
    m_prio = 0;
  endtask

  task automatic test_random();
    int gnt, waits, lat, exp_gnt, sel, hold;
    logic [3:0] op0, op1;
    logic [31:0] a0, b0, a1, b1, data, exp_data;
    bit stable, quiet, tmo, spur;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(1, 3);
      op0 = 4'($urandom_range(0, 15)); op1 = 4'($urandom_range(0, 15));
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      hold = $urandom_range(0, 3);
      spur = 1'($urandom_range(0, 1));
      if (sel == 3) exp_gnt = FIXED ? 0 : m_prio;
      else          exp_gnt = (sel == 1) ? 0 : 1;
      exp_data = (exp_gnt == 0) ? expect_res(op0, a0, b0) : expect_res(op1, a1, b1);
      issue(sel[0], sel[1], op0, a0, b0, op1, a1, b1, gnt, waits);
      total++; if (gnt !== exp_gnt) begin bad++; $display("FAIL rand_gnt n=%0d got=%0d want=%0d", n, gnt, exp_gnt); end
      wait_rsp(exp_gnt, hold, spur, lat, data, stable, quiet, tmo);
      total++; if (data !== exp_data || tmo) begin bad++; $display("FAIL rand_data n=%0d got=%h want=%h", n, data, exp_data); end
      total++; if (lat !== 2 || !stable || !quiet) begin bad++; $display("FAIL rand_timing n=%0d got=%0d/%0b%0b want=2/11", n, lat, stable, quiet); end
      idle_inputs();
      m_prio = 1 - exp_gnt;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_spurious();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
